// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared button FSM encoding, timing defaults and counter sizing
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HELD   = 2'b01,
    REPEAT = 2'b10
  } btn_state_t;

  // Timing defaults for a 50 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int DEFAULT_HOLD_CYCLES     = 50000000;  // 1 s
  localparam int DEFAULT_REPEAT_CYCLES   = 10000000;  // 200 ms

  // Width of a counter that runs 0 .. n-1 and clears at terminal count.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser plus stability counter producing a debounced level and edge strobes
module button_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          btn_sync;
  logic          btn_sample;
  logic [CW-1:0] count;
  logic          accept;

  // Two-flop synchroniser, then one sample stage feeding the stability counter so the
  // accepted change lands DEBOUNCE_CYCLES+2 edges after the raw level is first sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      btn_sync   <= 1'b0;
      btn_sample <= 1'b0;
    end else begin
      sync1      <= btn_raw;
      btn_sync   <= sync1;
      btn_sample <= btn_sync;
    end
  end

  // A change is accepted on the edge where the mismatch has persisted for the full count.
  assign accept = (btn_sample != btn_level) && (count == TERM);
  assign rise   = accept && btn_sample;
  assign fall   = accept && !btn_sample;

  // Stability counter: any sample that agrees with the current level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      btn_level <= 1'b0;
    end else if (btn_sample == btn_level) begin
      count <= '0;
    end else if (count == TERM) begin
      btn_level <= btn_sample;
      count     <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced button with press/release/repeat pulses and long-press flag
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic long_press
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);
  localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_TERM  = RW'(REPEAT_CYCLES - 1);
  localparam logic          REP_ON    = (REPEAT_EN != 0);

  logic          rise;
  logic          fall;
  btn_state_t    state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [RW-1:0] rep_cnt, rep_cnt_n;
  logic          press_n, release_n, repeat_n, step_n, long_n;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .rise     (rise),
    .fall     (fall)
  );

  // Next-state and next-output logic; a fall always wins over a terminal count.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    rep_cnt_n  = rep_cnt;
    press_n    = 1'b0;
    release_n  = 1'b0;
    repeat_n   = 1'b0;
    step_n     = 1'b0;
    long_n     = long_press;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n    = HELD;
          press_n    = 1'b1;
          step_n     = 1'b1;
          hold_cnt_n = '0;
        end
      end
      HELD: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else if (hold_cnt == HOLD_TERM) begin
          state_n   = REPEAT;
          long_n    = 1'b1;
          repeat_n  = REP_ON;
          step_n    = REP_ON;
          rep_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          long_n    = 1'b0;
        end else if (rep_cnt == REP_TERM) begin
          repeat_n  = REP_ON;
          step_n    = REP_ON;
          rep_cnt_n = '0;
        end else begin
          rep_cnt_n = rep_cnt + RW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        long_n  = 1'b0;
      end
    endcase
  end

  // State, counters and registered one-cycle pulses; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      step_pulse    <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_cnt_n;
      rep_cnt       <= rep_cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      repeat_pulse  <= repeat_n;
      step_pulse    <= step_n;
      long_press    <= long_n;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with short timing parameters
module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse, long_press;

  // Observed vector: {btn_level, press, release, repeat, step, long_press}
  logic [5:0] obs;
  logic [5:0] exp_v;
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .REPEAT_EN      (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .step_pulse   (step_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  task automatic sample();
    obs = {btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse, long_press};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic do_reset();
    btn_raw = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Expected outputs for a held press starting at edge 0 with raw first sampled low at edge rel_edge.
  function automatic logic [5:0] held_exp(input int e, input int rel_edge);
    logic lvl, prs, rls, rpt, lng;
    lvl = (e >= 6) && (e < rel_edge + 6);
    prs = (e == 6);
    rls = (e == rel_edge + 6);
    lng = (e >= 16) && (e < rel_edge + 6);
    rpt = lng && ((e - 16) % 3 == 0);
    return {lvl, prs, rls, rpt, prs | rpt, lng};
  endfunction

  task automatic test_reset();
    btn_raw = 1'b0;
    reset   = 1'b1;
    #1;
    sample();
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got %b want %b", obs, 6'b0);
    end
    for (int e = 0; e < 3; e++) exp_q.push_back(6'b0);
    for (int e = 0; e < 3; e++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_held edge %0d got %b want %b", e, obs, exp_v);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 50; e++) exp_q.push_back(6'b0);
    for (int e = 0; e < 50; e++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle edge %0d got %b want %b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_press();
    do_reset();
    btn_raw = 1'b1;
    for (int e = 0; e < 10; e++) exp_q.push_back(held_exp(e, 1000));
    for (int e = 0; e < 10; e++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL press edge %0d got %b want %b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int e = 0; e < 30; e++) exp_q.push_back(6'b0);
    for (int e = 0; e < 30; e++) begin
      btn_raw = ((e % 6) < 3);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce edge %0d got %b want %b", e, obs, exp_v);
      end
    end
    btn_raw = 1'b0;
  endtask

  task automatic test_long_repeat();
    do_reset();
    for (int e = 0; e < 46; e++) exp_q.push_back(held_exp(e, 30));
    for (int e = 0; e < 46; e++) begin
      btn_raw = (e < 30);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_repeat edge %0d got %b want %b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_short_press();
    do_reset();
    for (int e = 0; e < 25; e++) exp_q.push_back(held_exp(e, 8));
    for (int e = 0; e < 25; e++) begin
      btn_raw = (e < 8);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short_press edge %0d got %b want %b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    do_reset();
    btn_raw = 1'b1;
    for (int e = 0; e < 21; e++) exp_q.push_back(held_exp(e, 1000));
    for (int e = 0; e < 21; e++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pre_reset edge %0d got %b want %b", e, obs, exp_v);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    sample();
    checks++;
    if (obs !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_repeat got %b want %b", obs, 6'b0);
    end
    #1;
    reset = 1'b0;
    for (int e = 0; e < 11; e++) exp_q.push_back(held_exp(e, 1000));
    for (int e = 0; e < 11; e++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset edge %0d got %b want %b", e, obs, exp_v);
      end
    end
    btn_raw = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_long_repeat();
    test_short_press();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
